// File: rtl/boot_pkg.sv
// Shared types and field geometry for the UART boot loader.
// No logic; constants only.
// Field lengths are in bytes and drive the byte-shifter index compares.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CNT,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_e;

    localparam logic [7:0] MAGIC_DEF  = 8'hA5;
    localparam int         ADDR_BYTES = 4;
    localparam int         CNT_BYTES  = 2;
    localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/boot_byte_shifter.sv
// Little-endian byte assembler: byte k of a field lands in word[8k+7:8k].
// Zero latency: word shows the incoming byte merged in the same cycle.
// No backpressure; the caller gates en with its own accept condition.
module boot_byte_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  byte_dat,
    output logic [1:0]  idx,
    output logic [31:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (en) begin
            word_d[idx_q*8 +: 8] = byte_dat;
            idx_d                = idx_q + 2'd1;
        end
        // Clearing wins so the last byte of a field can also restart the index.
        if (clr) begin
            idx_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= 2'd0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign idx  = idx_q;
    assign word = word_d;

endmodule

// File: rtl/uart_boot_loader.sv
// Parses a framed image from the UART byte stream and writes it to memory as 32-bit words.
// Latency: bus write requested the cycle after the 4th data byte; done/err one cycle after the checksum.
// Backpressure: rx_ready drops while a write waits for bus_gnt; stalls never count toward the timeout.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter logic [7:0] MAGIC       = MAGIC_DEF,
    parameter int          CNT_W       = 16,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        bus_gnt,
    output logic        bus_en,
    output logic        bus_rdwr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wr_data,
    output logic [3:0]  bus_mask,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam int               TMO_W     = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       ADDR_LAST = 2'(ADDR_BYTES - 1);
    localparam logic [1:0]       CNT_LAST  = 2'(CNT_BYTES - 1);
    localparam logic [1:0]       WORD_LAST = 2'(WORD_BYTES - 1);

    boot_state_e      state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       csum_q, csum_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    logic        accept;
    logic        sh_en;
    logic        sh_clr;
    logic [1:0]  sh_idx;
    logic [31:0] sh_word;

    assign rx_ready = state_q inside {ST_IDLE, ST_ADDR, ST_CNT, ST_DATA, ST_CSUM};
    assign accept   = rx_valid & rx_ready;

    boot_byte_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clr      (sh_clr),
        .en       (sh_en),
        .byte_dat (rx_data),
        .idx      (sh_idx),
        .word     (sh_word)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        bus_en  = 1'b0;
        sh_en   = 1'b0;
        sh_clr  = 1'b0;

        // Idle-gap timer runs only while waiting on the UART inside a frame.
        if (state_q inside {ST_ADDR, ST_CNT, ST_DATA, ST_CSUM}) begin
            if (accept) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                state_d = ST_ERR;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end else if (state_q != ST_WRITE) begin
            tmo_d = '0;
        end

        if (accept && (state_q inside {ST_ADDR, ST_CNT, ST_DATA})) begin
            sh_en  = 1'b1;
            csum_d = csum_q ^ rx_data;
        end

        case (state_q)
            ST_IDLE: begin
                sh_clr = 1'b1;
                if (accept && (rx_data == MAGIC)) begin
                    err_d   = 1'b0;
                    csum_d  = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (accept && (sh_idx == ADDR_LAST)) begin
                    sh_clr  = 1'b1;
                    addr_d  = sh_word;
                    state_d = (sh_word[1:0] != 2'b00) ? ST_ERR : ST_CNT;
                end
            end
            ST_CNT: begin
                if (accept && (sh_idx == CNT_LAST)) begin
                    sh_clr  = 1'b1;
                    cnt_d   = sh_word[CNT_W-1:0];
                    state_d = (sh_word[CNT_W-1:0] == '0) ? ST_CSUM : ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept && (sh_idx == WORD_LAST)) begin
                    sh_clr  = 1'b1;
                    wdata_d = sh_word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                bus_en = 1'b1;
                if (bus_gnt) begin
                    addr_d  = addr_q + 32'd4;
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(1)) ? ST_CSUM : ST_DATA;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ERR) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign bus_rdwr    = bus_en;
    assign bus_mask    = {4{bus_en}};
    assign bus_addr    = addr_q;
    assign bus_wr_data = wdata_q;
    assign cpu_hold    = state_q inside {ST_ADDR, ST_CNT, ST_DATA, ST_WRITE, ST_CSUM};
    assign load_done   = (state_q == ST_DONE);
    assign load_err    = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench: a frame-level reference model queues expected writes and outcomes;
// a monitor pops and compares whenever the loader writes, finishes or errors.
module tb_uart_boot_loader;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        bus_gnt = 1'b0;
    logic        bus_en;
    logic        bus_rdwr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [3:0]  bus_mask;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int          tests = 0;
    int          fails = 0;
    int          gnt_mode = 1;
    logic [63:0] wq[$];
    int          oq[$];
    logic [7:0]  frame[$];
    logic [31:0] wbuf[8];
    logic        prev_err = 1'b0;
    logic [63:0] mon_e;
    int          sk;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .MAGIC       (8'hA5),
        .CNT_W       (16),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .bus_gnt     (bus_gnt),
        .bus_en      (bus_en),
        .bus_rdwr    (bus_rdwr),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_mask    (bus_mask),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: 1 = load_done, 2 = load_err.
    task automatic model_frame();
        logic [31:0] a;
        logic [7:0]  x;
        int          n;
        a = {frame[4], frame[3], frame[2], frame[1]};
        if ((a % 4) != 0) begin
            oq.push_back(2);
            return;
        end
        n = int'({frame[6], frame[5]});
        x = 8'h00;
        for (int i = 1; i < 7 + 4 * n; i++) x ^= frame[i];
        for (int i = 0; i < n; i++)
            wq.push_back({a + 32'(4 * i),
                          frame[10 + 4 * i], frame[9 + 4 * i], frame[8 + 4 * i], frame[7 + 4 * i]});
        oq.push_back((frame[7 + 4 * n] == x) ? 1 : 2);
    endtask

    task automatic build(input logic [31:0] a, input logic [15:0] n, input bit bad, input logic [7:0] badv);
        logic [7:0] x;
        frame.delete();
        frame.push_back(8'hA5);
        for (int i = 0; i < 4; i++) frame.push_back(a[8 * i +: 8]);
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        for (int w = 0; w < int'(n); w++)
            for (int i = 0; i < 4; i++) frame.push_back(wbuf[w][8 * i +: 8]);
        x = 8'h00;
        for (int i = 1; i < frame.size(); i++) x ^= frame[i];
        frame.push_back(bad ? badv : x);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && k < 300) begin
            k++;
            @(negedge clk);
        end
        if (!rx_ready) check("rx_accept_timeout", 64'(rx_ready), 64'(1));
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int maxgap);
        model_frame();
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i]);
            if (i == 0) begin
                check("hold_after_magic", 64'(cpu_hold), 64'(1));
                check("err_clear_on_magic", 64'(load_err), 64'(0));
            end
            repeat ($urandom_range(0, maxgap)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input int bound);
        int k;
        k = 0;
        while ((wq.size() != 0 || oq.size() != 0) && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("drain", 64'(wq.size() + oq.size()), 64'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check("rst_rx_ready", 64'(rx_ready), 64'(1));
        check("rst_bus_en", 64'(bus_en), 64'(0));
        check("rst_bus_rdwr", 64'(bus_rdwr), 64'(0));
        check("rst_bus_mask", 64'(bus_mask), 64'(0));
        check("rst_bus_addr", 64'(bus_addr), 64'(0));
        check("rst_bus_wr_data", 64'(bus_wr_data), 64'(0));
        check("rst_cpu_hold", 64'(cpu_hold), 64'(0));
        check("rst_load_done", 64'(load_done), 64'(0));
        check("rst_load_err", 64'(load_err), 64'(0));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (gnt_mode)
                0:       bus_gnt = 1'($urandom_range(0, 1));
                1:       bus_gnt = 1'b1;
                default: bus_gnt = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus_en) begin
                    check("wr_mask", 64'(bus_mask), 64'(4'hF));
                    check("wr_rdwr", 64'(bus_rdwr), 64'(1));
                    check("wr_rx_ready", 64'(rx_ready), 64'(0));
                    check("wr_hold", 64'(cpu_hold), 64'(1));
                    if (bus_gnt) begin
                        if (wq.size() == 0) begin
                            check("write_expected", 64'(bus_en), 64'(0));
                        end else begin
                            mon_e = wq.pop_front();
                            check("wr_addr", 64'(bus_addr), 64'(mon_e[63:32]));
                            check("wr_data", 64'(bus_wr_data), 64'(mon_e[31:0]));
                        end
                    end
                end
                if (load_done) begin
                    check("done_hold", 64'(cpu_hold), 64'(0));
                    if (oq.size() == 0) check("done_expected", 64'(load_done), 64'(0));
                    else check("outcome_done", 64'(1), 64'(oq.pop_front()));
                end
                if (load_err && !prev_err) begin
                    check("err_hold", 64'(cpu_hold), 64'(0));
                    if (oq.size() == 0) check("err_expected", 64'(load_err), 64'(0));
                    else check("outcome_err", 64'(2), 64'(oq.pop_front()));
                end
            end
            prev_err = load_err;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset();

        // Reference frame: base 0x100, two words.
        wbuf[0] = 32'h44332211;
        wbuf[1] = 32'h88776655;
        build(32'h0000_0100, 16'd2, 1'b0, 8'h00);
        send_frame(0);
        wait_drain(50);

        // Same frame, wrong checksum: writes still land, then error.
        build(32'h0000_0100, 16'd2, 1'b1, 8'h00);
        send_frame(0);
        wait_drain(50);
        check("err_sticky", 64'(load_err), 64'(1));
        check("err_no_hold", 64'(cpu_hold), 64'(0));

        // Misaligned base: only the header reaches the loader.
        build(32'h0000_0102, 16'd1, 1'b0, 8'h00);
        frame = frame[0:4];
        send_frame(0);
        wait_drain(20);
        build(32'h0000_0100, 16'd2, 1'b0, 8'h00);
        send_frame(1);
        wait_drain(50);
        check("err_cleared", 64'(load_err), 64'(0));

        // Zero-length image.
        build(32'h0000_0100, 16'd0, 1'b0, 8'h00);
        send_frame(0);
        wait_drain(20);

        // Bus stall of 50 cycles during a write.
        wbuf[0] = 32'hCAFEF00D;
        build(32'h0000_0300, 16'd1, 1'b0, 8'h00);
        gnt_mode = 2;
        fork
            send_frame(0);
            begin
                sk = 0;
                while (!bus_en && sk < 500) begin
                    @(negedge clk);
                    sk++;
                end
                check("stall_reach_write", 64'(bus_en), 64'(1));
                repeat (50) begin
                    @(negedge clk);
                    check("stall_en", 64'(bus_en), 64'(1));
                    check("stall_addr", 64'(bus_addr), 64'(32'h0000_0300));
                    check("stall_data", 64'(bus_wr_data), 64'(32'hCAFEF00D));
                    check("stall_rx_ready", 64'(rx_ready), 64'(0));
                end
                gnt_mode = 1;
                @(negedge clk);
                check("gnt_write_cycle", 64'({bus_gnt, bus_en}), 64'(2'b11));
                @(negedge clk);
                check("write_released", 64'(bus_en), 64'(0));
            end
        join
        wait_drain(50);

        // Sender goes quiet mid-DATA.
        wbuf[0] = 32'h0BADBEEF;
        build(32'h0000_0200, 16'd1, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) send_byte(frame[i]);
        oq.push_back(2);
        repeat (10) @(negedge clk);
        check("no_early_timeout", 64'(load_err), 64'(0));
        wait_drain(20);
        check("timeout_no_hold", 64'(cpu_hold), 64'(0));

        // Reset in the middle of the second word, after the first write.
        wbuf[0] = 32'h1234_5678;
        wbuf[1] = 32'h9ABC_DEF0;
        build(32'h0000_0400, 16'd2, 1'b0, 8'h00);
        wq.push_back({32'h0000_0400, 32'h1234_5678});
        for (int i = 0; i < 13; i++) send_byte(frame[i]);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset();
        wait_drain(5);
        wbuf[0] = 32'h44332211;
        wbuf[1] = 32'h88776655;
        build(32'h0000_0100, 16'd2, 1'b0, 8'h00);
        send_frame(0);
        wait_drain(50);

        // Randomized frames with random grant, gaps, leading noise and address wrap.
        gnt_mode = 0;
        for (int f = 0; f < 12; f++) begin
            logic [31:0] a;
            logic [15:0] n;
            logic [7:0]  g;
            bit          bad;
            a = (f % 4 == 3) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            n = 16'($urandom_range(0, 4));
            for (int w = 0; w < 8; w++) wbuf[w] = $urandom;
            bad = ($urandom_range(0, 3) == 0);
            build(a, n, bad, frame.size() == 0 ? 8'h00 : 8'h00);
            if (bad) frame[frame.size() - 1] = ~frame[frame.size() - 1];
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g);
            end
            send_frame(3);
            wait_drain(400);
        end

        check("final_wq_empty", 64'(wq.size()), 64'(0));
        check("final_oq_empty", 64'(oq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
